// File: rtl/irq_router.sv
// Dock bus interrupt collector/arbiter: synchronises, masks and arbitrates slot IRQs, runs the INTA handshake.
// Optional rotating priority is compiled in with `define IRQ_ROTATE_EN.
module irq_router #(
    parameter int         NUM_SLOTS    = 5,
    parameter int         SLOT_W       = 3,
    parameter logic [7:0] IRQ_CFG_BASE = 8'hC0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] slot_irq_n,
    input  logic                 inta_n,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic                 cpu_int_n,
    output logic                 irq_int_active,
    output logic [SLOT_W-1:0]    irq_int_slot,
    output logic                 irq_vec_cycle,
    output logic                 spurious_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [NUM_SLOTS-1:0] sync1;
    logic [NUM_SLOTS-1:0] sync2;
    logic [NUM_SLOTS-1:0] en_mask;
    logic [NUM_SLOTS-1:0] req;
    logic [1:0]           state;
    logic [1:0]           state_nx;
    logic [SLOT_W-1:0]    cur_slot;
    logic [SLOT_W-1:0]    cur_slot_nx;
    logic [SLOT_W-1:0]    win_slot;
    logic [SLOT_W-1:0]    start_slot;
    logic                 win_found;
    logic                 inta_prev;
    logic                 spur_nx;
    int unsigned          idx;
    logic                 unused_cfg;

    assign unused_cfg = ^cfg_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= slot_irq_n;
            sync2 <= sync1;
        end
    end

    assign req = ~sync2 & en_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_mask <= '0;
        end else if (cfg_we && cfg_addr == IRQ_CFG_BASE) begin
            en_mask <= cfg_wdata[NUM_SLOTS-1:0];
        end
    end

`ifdef IRQ_ROTATE_EN
    logic              rot_en;
    logic [SLOT_W-1:0] last_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_en    <= 1'b0;
            last_slot <= SLOT_W'(NUM_SLOTS - 1);
        end else begin
            if (cfg_we && cfg_addr == IRQ_CFG_BASE + 8'd1) begin
                rot_en <= cfg_wdata[0];
            end
            if (state == ST_ACK && inta_n) begin
                last_slot <= cur_slot;
            end
        end
    end
`endif

    // Fixed priority is the rotating search with its start pinned at slot 0.
    always_comb begin
        start_slot = '0;
`ifdef IRQ_ROTATE_EN
        if (rot_en) begin
            start_slot = (last_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : last_slot + 1'b1;
        end
`endif
        win_found = 1'b0;
        win_slot  = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            idx = 32'(start_slot) + i;
            if (idx >= NUM_SLOTS) begin
                idx = idx - NUM_SLOTS;
            end
            if (!win_found && req[idx[SLOT_W-1:0]]) begin
                win_found = 1'b1;
                win_slot  = idx[SLOT_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cur_slot_nx = cur_slot;
        spur_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!inta_n && inta_prev) begin
                    spur_nx = 1'b1;
                end
                if (win_found) begin
                    state_nx    = ST_PEND;
                    cur_slot_nx = win_slot;
                end
            end
            ST_PEND: begin
                if (!inta_n) begin
                    state_nx = ST_ACK;
                end else if (!req[cur_slot]) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (inta_n) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cur_slot       <= '0;
            inta_prev      <= 1'b1;
            cpu_int_n      <= 1'b1;
            irq_int_active <= 1'b0;
            irq_int_slot   <= '0;
            irq_vec_cycle  <= 1'b0;
            spurious_ack   <= 1'b0;
        end else begin
            state          <= state_nx;
            cur_slot       <= cur_slot_nx;
            inta_prev      <= inta_n;
            cpu_int_n      <= (state_nx != ST_PEND);
            irq_int_active <= (state_nx == ST_PEND) || (state_nx == ST_ACK);
            irq_int_slot   <= cur_slot_nx;
            irq_vec_cycle  <= (state_nx == ST_ACK);
            spurious_ack   <= spur_nx;
        end
    end

endmodule

// File: doc/irq_router.md
# irq_router

Interrupt collector/arbiter for the Dock bus. It synchronises and masks the per-slot active-low interrupt lines and selects one winning slot. It drives the single CPU interrupt line and runs the interrupt-acknowledge handshake. It produces `irq_int_active`, `irq_int_slot` and `irq_vec_cycle`, which `addr_decoder` consumes to route the vector-fetch cycle to the interrupting slot.

## Interface
Parameters:
- `NUM_SLOTS`, 5, number of expansion slots / interrupt inputs (2..8).
- `SLOT_W`, 3, width of slot index; `2**SLOT_W >= NUM_SLOTS`.
- `IRQ_CFG_BASE`, 8'hC0, base config address of this block's registers.

Ports (clk first; one clock, reset is synchronous and active-high):
- `clk` in 1 — Dock bus clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `slot_irq_n` in NUM_SLOTS — per-slot interrupt request, active low, asynchronous to clk.
- `inta_n` in 1 — CPU interrupt-acknowledge strobe, active low, synchronous to clk.
- `cfg_we` in 1 — config write strobe, synchronous to clk.
- `cfg_addr` in 8 — config address.
- `cfg_wdata` in 8 — config write data.
- `cpu_int_n` out 1 — interrupt request to CPU, active low.
- `irq_int_active` out 1 — an interrupt is latched (pending or in acknowledge).
- `irq_int_slot` out SLOT_W — latched winning slot; stable while `irq_int_active`.
- `irq_vec_cycle` out 1 — acknowledge/vector cycle in progress; to `addr_decoder`.
- `spurious_ack` out 1 — one-cycle pulse when `inta_n` falls with no latched interrupt.

## Operation
- Synchroniser: each `slot_irq_n` bit passes through 2 flops (reset value 1).
- `req[i]` = synchronised line low AND `en_mask[i]`.
- Registers, written when `cfg_we` is high:
  - `IRQ_CFG_BASE+0`: `en_mask` = `cfg_wdata[NUM_SLOTS-1:0]`; reset 0, all disabled.
  - `IRQ_CFG_BASE+1`: bit0 = `rot_en`; reset 0.
  - Other addresses are ignored.
- Arbitration:
  - Fixed priority: lowest-numbered requesting slot wins.
  - Rotating priority (see Configuration): search starts at `(last_slot+1) mod NUM_SLOTS` and wraps. `last_slot` resets to NUM_SLOTS-1, so the first search starts at slot 0.
- FSM states IDLE, PEND, ACK:
  - IDLE: any `req` → latch winner into `cur_slot`, go PEND. `inta_n` falling (low this cycle, high previous) → `spurious_ack` pulse, stay IDLE.
  - PEND: `inta_n` low → ACK. Otherwise, if `req[cur_slot]` is 0 (slot withdrew or was masked) → IDLE. `inta_n` low wins over a simultaneous withdraw.
  - ACK: `inta_n` high → IDLE and `last_slot <= cur_slot`. A withdraw or mask change during ACK is ignored.
- Outputs are registered, decoded from next state:
  - `cpu_int_n` = 0 only in PEND.
  - `irq_int_active` = 1 in PEND and ACK.
  - `irq_vec_cycle` = 1 only in ACK.
  - `irq_int_slot` = `cur_slot`; it holds its last value in IDLE.
- Config writes take effect for the arbitration evaluated on the following edge.

## Timing
- Reset (`rst` high at an edge): state IDLE, `cpu_int_n`=1, `irq_int_active`=0, `irq_int_slot`=0, `irq_vec_cycle`=0, `spurious_ack`=0, `en_mask`=0, `rot_en`=0. Applies from any state, including mid-ACK.
- Request latency: the first edge E0 samples `slot_irq_n` low. Outputs are `cpu_int_n`=0 and `irq_int_active`=1 after edge E0+2.
- Ack latency: `inta_n` sampled low at edge A → after A, `irq_vec_cycle`=1 and `cpu_int_n`=1.
- Release: `inta_n` sampled high at edge B → after B, `irq_vec_cycle`=0 and `irq_int_active`=0.
- At least one IDLE cycle separates consecutive interrupts. The earliest next PEND is after edge B+1.
- Simultaneous requests are resolved in the same cycle by the active priority scheme.

## Configuration
- `IRQ_ROTATE_EN` defined: rotating-priority logic and `last_slot` are compiled in. Rotation is active when `rot_en`=1; `rot_en`=0 gives fixed priority.
- `IRQ_ROTATE_EN` undefined: fixed priority only. `rot_en`/`last_slot` are absent, and writes to `IRQ_CFG_BASE+1` are ignored.

## Test plan
- Write `en_mask`=0x1F. Drive `slot_irq_n`=5'b11101 → `cpu_int_n`=0 and `irq_int_slot`=1 after 3 edges. Drive `inta_n` low 2 cycles → `irq_vec_cycle`=1 for 2 cycles, then all outputs idle.
- `en_mask`=0x1D, `slot_irq_n`=5'b11101 (slot 1 masked) → `cpu_int_n` stays 1 for 10 cycles. Write `en_mask`=0x1F → `cpu_int_n`=0 within 2 cycles, slot 1.
- Slots 1 and 3 simultaneously low, fixed priority → slot 1 is served. After ack with both still asserted → slot 1 again. With `IRQ_ROTATE_EN` and `rot_en`=1 → slot 3 second, then slot 1.
- In PEND for slot 2, release `slot_irq_n[2]` before ack → `cpu_int_n`=1 and `irq_int_active`=0 within 3 cycles, no `irq_vec_cycle`.
- `inta_n` pulsed low in IDLE → `spurious_ack`=1 for exactly 1 cycle, `irq_vec_cycle` stays 0.
- `rst` asserted during ACK → next cycle all outputs at reset values and `en_mask`=0.
